// File: rtl/fp_mul_seq.sv
// -----------------------------------------------------------------------------
// fp_mul_seq : sequential IEEE-754 style floating-point multiplier
//
// Multiplies two {sign, exponent, mantissa} operands with an iterative
// shift-add mantissa datapath. The unit processes one operation at a time.
// Subnormal inputs are flushed to zero, and no subnormal results are produced.
//
// Parameters
//   EXP_W : exponent field width
//   MAN_W : stored mantissa width, hidden bit excluded, MAN_W >= 2
//
// Ports
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   in_valid  : operands present
//   in_ready  : unit idle and able to take operands
//   in1, in2  : operands, W = 1+EXP_W+MAN_W bits
//   out_valid : result present, held until out_ready
//   out_ready : consumer accepts result
//   result    : product
//
// Build option
//   FPMUL_RNE_EN : when defined, round to nearest even.
//                  When undefined, truncate (round toward zero).
//                  Latency is the same in both builds.
// -----------------------------------------------------------------------------
module fp_mul_seq #(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result
);

  localparam int N   = MAN_W + 1;          // mantissa width with hidden bit
  localparam int PW  = 2 * N;              // product register width
  localparam int EW  = EXP_W + 2;          // signed working exponent width
  localparam int CW  = $clog2(MAN_W + 1);  // iteration counter width

  localparam int BIAS_I = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX_I = (1 << EXP_W) - 1;

  localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS_I);
  localparam logic signed [EW-1:0] EMAX_E = EW'(EMAX_I);
  localparam logic signed [EW-1:0] ONE_E  = EW'(1);
  localparam logic signed [EW-1:0] ZERO_E = EW'(0);

  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W-1:0] EXP_ZERO = '0;
  localparam logic [MAN_W-1:0] MAN_ZERO = '0;
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  // LOAD sits between IDLE and MUL, and classifies the captured operands.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MUL  = 3'd2,
    S_NORM = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [W-1:0]           a_q, a_d, b_q, b_d;
  logic                   sign_q, sign_d;
  logic signed [EW-1:0]   exp_q, exp_d;
  logic [N-1:0]           mcand_q, mcand_d;
  logic [PW-1:0]          prod_q, prod_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [W-1:0]           result_q, result_d;
  logic                   out_valid_q, out_valid_d;
  logic                   in_ready_q, in_ready_d;

  logic [EXP_W-1:0] a_exp_s, b_exp_s;
  logic [MAN_W-1:0] a_man_s, b_man_s;
  logic             a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
  logic [N:0]       psum_s;

  logic                 top_s;
  logic [MAN_W-1:0]     man_s, man_rnd_s;
  logic signed [EW-1:0] exp_n_s, exp_r_s;
  logic [W-1:0]         norm_res_s;
`ifdef FPMUL_RNE_EN
  logic                 guard_s, sticky_s, inc_s;
  logic [MAN_W:0]       man_sum_s;
`endif

  assign a_exp_s  = a_q[W-2:MAN_W];
  assign b_exp_s  = b_q[W-2:MAN_W];
  assign a_man_s  = a_q[MAN_W-1:0];
  assign b_man_s  = b_q[MAN_W-1:0];
  assign a_zero_s = (a_exp_s == EXP_ZERO);
  assign b_zero_s = (b_exp_s == EXP_ZERO);
  assign a_inf_s  = (a_exp_s == EXP_ONES) && (a_man_s == MAN_ZERO);
  assign b_inf_s  = (b_exp_s == EXP_ONES) && (b_man_s == MAN_ZERO);
  assign a_nan_s  = (a_exp_s == EXP_ONES) && (a_man_s != MAN_ZERO);
  assign b_nan_s  = (b_exp_s == EXP_ONES) && (b_man_s != MAN_ZERO);

  // Shift-add step: the multiplier occupies the low half of prod_q and is
  // consumed LSB first while partial sums accumulate into the upper half.
  assign psum_s = {1'b0, prod_q[PW-1:N]} + {1'b0, (prod_q[0] ? mcand_q : {N{1'b0}})};

  // Normalise, round and range-check the finished product.
  always_comb begin
    // The product of two [1,2) mantissas lies in [1,4), so the leading one
    // is at bit PW-1 or at bit PW-2.
    top_s   = prod_q[PW-1];
    man_s   = top_s ? prod_q[PW-2:N] : prod_q[PW-3:N-1];
    exp_n_s = exp_q + (top_s ? ONE_E : ZERO_E);
`ifdef FPMUL_RNE_EN
    guard_s   = top_s ? prod_q[N-1] : prod_q[N-2];
    sticky_s  = top_s ? (|prod_q[N-2:0]) : (|prod_q[N-3:0]);
    inc_s     = guard_s & (sticky_s | man_s[0]);
    man_sum_s = {1'b0, man_s} + {{MAN_W{1'b0}}, inc_s};
    // A carry out means the mantissa was all ones. The fraction is then
    // already zero, so only the exponent needs the extra +1.
    man_rnd_s = man_sum_s[MAN_W-1:0];
    exp_r_s   = exp_n_s + (man_sum_s[MAN_W] ? ONE_E : ZERO_E);
`else
    man_rnd_s = man_s;
    exp_r_s   = exp_n_s;
`endif
    if (exp_r_s >= EMAX_E) begin
      norm_res_s = {sign_q, EXP_ONES, MAN_ZERO};
    end else if (exp_r_s <= ZERO_E) begin
      norm_res_s = {sign_q, EXP_ZERO, MAN_ZERO};
    end else begin
      norm_res_s = {sign_q, exp_r_s[EXP_W-1:0], man_rnd_s};
    end
  end

  // Next-state and datapath update for the control FSM.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    mcand_d     = mcand_q;
    prod_d      = prod_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = in1;
          b_d        = in2;
          in_ready_d = 1'b0;
          state_d    = S_LOAD;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      S_LOAD: begin
        sign_d = a_q[W-1] ^ b_q[W-1];
        if (a_nan_s || b_nan_s || (a_inf_s && b_zero_s) || (b_inf_s && a_zero_s)) begin
          result_d    = QNAN;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else if (a_inf_s || b_inf_s) begin
          result_d    = {a_q[W-1] ^ b_q[W-1], EXP_ONES, MAN_ZERO};
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else if (a_zero_s || b_zero_s) begin
          result_d    = {a_q[W-1] ^ b_q[W-1], EXP_ZERO, MAN_ZERO};
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          mcand_d = {1'b1, a_man_s};
          prod_d  = {{N{1'b0}}, 1'b1, b_man_s};
          exp_d   = $signed({2'b00, a_exp_s}) + $signed({2'b00, b_exp_s}) - BIAS_E;
          cnt_d   = '0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        prod_d = {psum_s, prod_q[N-1:1]};
        if (cnt_q == CW'(MAN_W)) begin
          cnt_d   = '0;
          state_d = S_NORM;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_NORM: begin
        result_d    = norm_res_s;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, with a synchronous active-low reset that clears everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mcand_q     <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mcand_q     <= mcand_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule
